// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard scheduler producing stall/bubble controls and forwarding selects
//
// Ports:
//   clk          core clock
//   reset        synchronous active-low reset (0 = reset)
//   id_valid     ID holds a real instruction
//   id_rs/id_rt  ID read addresses
//   id_tuse_*    cycles from ID until the operand is needed (TUSE_NONE = unused)
//   id_waddr     ID destination register (0 = no write)
//   id_tnew      cycles after entering EX until the result exists
//   ext_hold     external stall request
//   stall        freeze PC and IF/ID
//   bubble_ex    load a NOP into ID/EX
//   fwd_id_*     ID operand mux select: 0 RF, 1 EX, 2 Mem, 3 WB
//   fwd_ex_*     EX operand mux select: 0 pipeline reg, 2 Mem, 3 WB
//   stall_count  stall cycles since reset (wraps)
module hazard_ctrl #(
   parameter int TW = 3,
   parameter logic [TW-1:0] TUSE_NONE = 3'd7,
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [4:0]      id_rs,
   input  logic [4:0]      id_rt,
   input  logic [TW-1:0]   id_tuse_rs,
   input  logic [TW-1:0]   id_tuse_rt,
   input  logic [4:0]      id_waddr,
   input  logic [TW-1:0]   id_tnew,
   input  logic            ext_hold,
   output logic            stall,
   output logic            bubble_ex,
   output logic [1:0]      fwd_id_rs,
   output logic [1:0]      fwd_id_rt,
   output logic [1:0]      fwd_ex_rs,
   output logic [1:0]      fwd_ex_rt,
   output logic [CNTW-1:0] stall_count
);

   logic          ex_valid, mem_valid, wb_valid;
   logic [4:0]    ex_waddr, mem_waddr, wb_waddr, ex_rs, ex_rt;
   logic [TW-1:0] ex_tnew, mem_tnew, wb_tnew;
   logic          hz_rs, hz_rt;

   function automatic logic hit(input logic v, input logic [4:0] w, input logic [4:0] r);
      return v && (w == r) && (r != 5'd0);
   endfunction

   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   // Nearest match decides; older matches are shadowed.
   function automatic logic haz3(input logic h_ex, input logic h_mem, input logic h_wb,
                                 input logic [TW-1:0] t_ex, input logic [TW-1:0] t_mem,
                                 input logic [TW-1:0] t_wb, input logic [TW-1:0] u);
      return (u != TUSE_NONE) && (h_ex ? (t_ex > u) : h_mem ? (t_mem > u) : (h_wb && (t_wb > u)));
   endfunction

   // A nearest match whose result is not ready yields 0; stall covers that case.
   function automatic logic [1:0] sel3(input logic h_ex, input logic h_mem, input logic h_wb,
                                       input logic [TW-1:0] t_ex, input logic [TW-1:0] t_mem,
                                       input logic [TW-1:0] t_wb);
      return h_ex  ? ((t_ex  == '0) ? 2'd1 : 2'd0) :
             h_mem ? ((t_mem == '0) ? 2'd2 : 2'd0) :
             h_wb  ? ((t_wb  == '0) ? 2'd3 : 2'd0) : 2'd0;
   endfunction

   always_comb begin
      hz_rs = haz3(hit(ex_valid, ex_waddr, id_rs), hit(mem_valid, mem_waddr, id_rs),
                   hit(wb_valid, wb_waddr, id_rs), ex_tnew, mem_tnew, wb_tnew, id_tuse_rs);
      hz_rt = haz3(hit(ex_valid, ex_waddr, id_rt), hit(mem_valid, mem_waddr, id_rt),
                   hit(wb_valid, wb_waddr, id_rt), ex_tnew, mem_tnew, wb_tnew, id_tuse_rt);
      // Reset overrides ext_hold so stall is quiet while in reset.
      stall = reset && (ext_hold || (id_valid && (hz_rs || hz_rt)));
      bubble_ex = stall;
      fwd_id_rs = sel3(hit(ex_valid, ex_waddr, id_rs), hit(mem_valid, mem_waddr, id_rs),
                       hit(wb_valid, wb_waddr, id_rs), ex_tnew, mem_tnew, wb_tnew);
      fwd_id_rt = sel3(hit(ex_valid, ex_waddr, id_rt), hit(mem_valid, mem_waddr, id_rt),
                       hit(wb_valid, wb_waddr, id_rt), ex_tnew, mem_tnew, wb_tnew);
      fwd_ex_rs = ex_valid ? sel3(1'b0, hit(mem_valid, mem_waddr, ex_rs),
                                  hit(wb_valid, wb_waddr, ex_rs), '0, mem_tnew, wb_tnew) : 2'd0;
      fwd_ex_rt = ex_valid ? sel3(1'b0, hit(mem_valid, mem_waddr, ex_rt),
                                  hit(wb_valid, wb_waddr, ex_rt), '0, mem_tnew, wb_tnew) : 2'd0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_valid    <= 1'b0;
         ex_waddr    <= '0;
         ex_tnew     <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         mem_valid   <= 1'b0;
         mem_waddr   <= '0;
         mem_tnew    <= '0;
         wb_valid    <= 1'b0;
         wb_waddr    <= '0;
         wb_tnew     <= '0;
         stall_count <= '0;
      end else begin
         ex_valid    <= id_valid && !stall;
         ex_waddr    <= (id_valid && !stall) ? id_waddr : 5'd0;
         ex_tnew     <= (id_valid && !stall) ? id_tnew : '0;
         ex_rs       <= (id_valid && !stall) ? id_rs : 5'd0;
         ex_rt       <= (id_valid && !stall) ? id_rt : 5'd0;
         mem_valid   <= ex_valid;
         mem_waddr   <= ex_waddr;
         mem_tnew    <= sat_dec(ex_tnew);
         wb_valid    <= mem_valid;
         wb_waddr    <= mem_waddr;
         wb_tnew     <= sat_dec(mem_tnew);
         stall_count <= stall ? stall_count + CNTW'(1) : stall_count;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall, bubble, forwarding and stall counting
module tb_hazard_ctrl;

   localparam logic [2:0] NONE = 3'd7;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_waddr;
   logic [2:0]  id_tuse_rs, id_tuse_rt, id_tnew;
   logic        ext_hold;
   logic        stall, bubble_ex;
   logic [1:0]  fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt;
   logic [31:0] stall_count;
   int          n_checks = 0;
   int          n_fail = 0;

   hazard_ctrl dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_waddr(id_waddr),
      .id_tnew(id_tnew), .ext_hold(ext_hold), .stall(stall), .bubble_ex(bubble_ex),
      .fwd_id_rs(fwd_id_rs), .fwd_id_rt(fwd_id_rt), .fwd_ex_rs(fwd_ex_rs),
      .fwd_ex_rt(fwd_ex_rt), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 1'b0;
      id_rs = 5'd0;
      id_rt = 5'd0;
      id_tuse_rs = NONE;
      id_tuse_rt = NONE;
      id_waddr = 5'd0;
      id_tnew = 3'd0;
      ext_hold = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rs, input logic [2:0] urs, input logic [4:0] rt,
                        input logic [2:0] urt, input logic [4:0] wa, input logic [2:0] tn);
      id_valid = 1'b1;
      id_rs = rs;
      id_tuse_rs = urs;
      id_rt = rt;
      id_tuse_rt = urt;
      id_waddr = wa;
      id_tnew = tn;
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b0;
      idle();
      repeat (2) tick();
      check("rst_stall", stall, 0);
      check("rst_bubble", bubble_ex, 0);
      check("rst_fwd", {fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt}, 0);
      check("rst_count", stall_count, 0);
      reset = 1'b1;
      tick();
      // load-use: lw $8 then addu rs=$8 tuse 1
      issue(5'd29, 3'd1, 5'd0, NONE, 5'd8, 3'd2);
      check("lw_nostall", stall, 0);
      tick();
      issue(5'd8, 3'd1, 5'd9, 3'd1, 5'd12, 3'd1);
      check("lu_stall", stall, 1);
      check("lu_bubble", bubble_ex, 1);
      tick();
      check("lu_release", stall, 0);
      check("lu_count", stall_count, 1);
      tick();
      idle();
      #1;
      check("lu_fwd_ex", fwd_ex_rs, 3);
      drain();
      // ALU result to branch
      issue(5'd0, NONE, 5'd0, NONE, 5'd9, 3'd1);
      tick();
      issue(5'd9, 3'd0, 5'd0, NONE, 5'd0, 3'd0);
      check("br_stall", stall, 1);
      tick();
      check("br_release", stall, 0);
      check("br_fwd_id", fwd_id_rs, 2);
      check("br_count", stall_count, 2);
      tick();
      drain();
      // lui then ori: forward from EX, no stall
      issue(5'd0, NONE, 5'd0, NONE, 5'd10, 3'd0);
      tick();
      issue(5'd10, 3'd1, 5'd0, NONE, 5'd13, 3'd1);
      check("lui_stall", stall, 0);
      check("lui_fwd_id", fwd_id_rs, 1);
      tick();
      idle();
      #1;
      check("lui_fwd_ex", fwd_ex_rs, 2);
      drain();
      // register zero never matches
      issue(5'd0, NONE, 5'd0, NONE, 5'd0, 3'd2);
      tick();
      issue(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0);
      check("r0_stall", stall, 0);
      check("r0_fwd", {fwd_id_rs, fwd_id_rt}, 0);
      tick();
      drain();
      // two writers to $11: nearest stage wins
      issue(5'd0, NONE, 5'd0, NONE, 5'd11, 3'd1);
      tick();
      issue(5'd0, NONE, 5'd0, NONE, 5'd11, 3'd0);
      tick();
      issue(5'd0, NONE, 5'd11, 3'd1, 5'd15, 3'd1);
      check("sh_stall", stall, 0);
      check("sh_fwd_id", fwd_id_rt, 1);
      tick();
      idle();
      #1;
      check("sh_fwd_ex", fwd_ex_rt, 2);
      drain();
      // ext_hold for 3 cycles with no instruction; pipeline keeps draining
      issue(5'd0, NONE, 5'd0, NONE, 5'd14, 3'd2);
      tick();
      idle();
      ext_hold = 1'b1;
      id_rs = 5'd14;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("hold_stall%0d", i), stall, 1);
         check($sformatf("hold_bubble%0d", i), bubble_ex, 1);
         check($sformatf("hold_fwd%0d", i), fwd_id_rs, (i == 2) ? 3 : 0);
         tick();
      end
      ext_hold = 1'b0;
      #1;
      check("hold_stall_off", stall, 0);
      check("hold_count", stall_count, 5);
      drain();
      // ext_hold overlapping a data hazard counts once
      issue(5'd0, NONE, 5'd0, NONE, 5'd8, 3'd2);
      tick();
      issue(5'd8, 3'd1, 5'd0, NONE, 5'd12, 3'd1);
      ext_hold = 1'b1;
      #1;
      check("both_stall", stall, 1);
      tick();
      ext_hold = 1'b0;
      #1;
      check("both_release", stall, 0);
      check("both_count", stall_count, 6);
      tick();
      drain();
      // reset during a load-use stall
      issue(5'd0, NONE, 5'd0, NONE, 5'd8, 3'd2);
      tick();
      issue(5'd8, 3'd1, 5'd0, NONE, 5'd12, 3'd1);
      check("rs_pre_stall", stall, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("rs_stall", stall, 0);
      check("rs_fwd", {fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt}, 0);
      check("rs_count", stall_count, 0);
      tick();
      issue(5'd29, 3'd1, 5'd0, NONE, 5'd8, 3'd2);
      tick();
      issue(5'd29, 3'd1, 5'd8, 3'd2, 5'd0, 3'd0);
      check("sw_stall", stall, 0);
      tick();
      idle();
      tick();
      check("sw_count", stall_count, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
